// File: rtl/seq_divider.sv
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Signed iterative restoring divider, one quotient bit per clock.
//             Optional macro DIV_REMAINDER_EN adds the signed remainder port r.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] ap,
   input  logic [WIDTH-1:0] bp,
   output logic [WIDTH-1:0] c,
   output logic             ex,
   output logic             busy,
   output logic             rdy
`ifdef DIV_REMAINDER_EN
   ,
   output logic [WIDTH-1:0] r
`endif
);

   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      SPECIAL = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             sign_q;
`ifdef DIV_REMAINDER_EN
   logic             sign_a;
`endif

   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] new_rem;
   logic [WIDTH-1:0] new_quo;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   // Zero magnitudes stay zero so no negative zero can appear.
   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                   input logic neg);
      return (neg && (mag != {WIDTH{1'b0}})) ? ({WIDTH{1'b0}} - mag) : mag;
   endfunction

   // One restoring step; the remainder always stays below the divisor.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      ge      = (shifted >= {1'b0, dvs});
      new_rem = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
      new_quo = {quo[WIDTH-2:0], ge};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         sign_q <= 1'b0;
         c      <= '0;
         ex     <= 1'b0;
         busy   <= 1'b0;
         rdy    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         sign_a <= 1'b0;
         r      <= '0;
`endif
      end else begin
         rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  quo    <= abs_val(ap);
                  dvs    <= abs_val(bp);
                  rem    <= '0;
                  cnt    <= '0;
                  sign_q <= ap[WIDTH-1] ^ bp[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                  sign_a <= ap[WIDTH-1];
`endif
                  busy   <= 1'b1;
                  if ((bp == '0) || ((ap == MIN_NEG) && (bp == ALL_ONES)))
                     state <= SPECIAL;
                  else
                     state <= RUN;
               end
            end
            RUN: begin
               rem <= new_rem;
               quo <= new_quo;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) begin
                  c     <= apply_sign(new_quo, sign_q);
                  ex    <= 1'b0;
`ifdef DIV_REMAINDER_EN
                  r     <= apply_sign(new_rem, sign_a);
`endif
                  busy  <= 1'b0;
                  rdy   <= 1'b1;
                  state <= DONE;
               end
            end
            SPECIAL: begin
               // A zero divisor magnitude means divide-by-zero; otherwise overflow.
               ex    <= 1'b1;
               busy  <= 1'b0;
               rdy   <= 1'b1;
               state <= DONE;
               if (dvs == '0) begin
                  c <= '0;
`ifdef DIV_REMAINDER_EN
                  r <= apply_sign(quo, sign_a);
`endif
               end else begin
                  c <= MIN_NEG;
`ifdef DIV_REMAINDER_EN
                  r <= '0;
`endif
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-level protocol model with
// arithmetic reference, random stimulus and literal anchor cases.
`default_nettype none

module tb_seq_divider;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [31:0] ap;
   logic [31:0] bp;
   logic [31:0] c;
   logic        ex;
   logic        busy;
   logic        rdy;
`ifdef DIV_REMAINDER_EN
   logic [31:0] r;
`endif

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH(32), .CNT_W(5)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .ap      (ap),
      .bp      (bp),
      .c       (c),
      .ex      (ex),
      .busy    (busy),
      .rdy     (rdy)
`ifdef DIV_REMAINDER_EN
      ,
      .r       (r)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the division rules.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] rm,
                          output logic e, output bit spec);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         q = 32'd0; rm = a; e = 1'b1; spec = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; rm = 32'd0; e = 1'b1; spec = 1'b1;
      end else begin
         q = 32'(sa / sb); rm = 32'(sa % sb); e = 1'b0; spec = 1'b0;
      end
   endtask

   // Protocol model: busy from acceptance until the result edge, then one rdy cycle.
   logic        m_busy = 1'b0, m_rdy = 1'b0, m_ex = 1'b0, p_ex;
   logic [31:0] m_c = '0, m_r = '0, p_c, p_r;
   int          left = 0;

   initial forever begin
      bit spec;
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         m_busy = 1'b0; m_rdy = 1'b0; m_c = '0; m_ex = 1'b0; m_r = '0; left = 0;
      end else if (m_rdy) begin
         m_rdy = 1'b0;
      end else if (!m_busy) begin
         if (start) begin
            ref_div(ap, bp, p_c, p_r, p_ex, spec);
            left   = spec ? 1 : 32;
            m_busy = 1'b1;
         end
      end else begin
         left--;
         if (left == 0) begin
            m_c = p_c; m_ex = p_ex; m_r = p_r;
            m_busy = 1'b0; m_rdy = 1'b1;
         end
      end
   end

   initial forever begin
      @(negedge clock);
      if (reset_n) begin
         check("busy", {31'd0, busy}, {31'd0, m_busy});
         check("rdy",  {31'd0, rdy},  {31'd0, m_rdy});
         check("c",    c,             m_c);
         check("ex",   {31'd0, ex},   {31'd0, m_ex});
`ifdef DIV_REMAINDER_EN
         check("r",    r,             m_r);
`endif
      end
   end

   function automatic logic [31:0] pick();
      int v;
      case ($urandom_range(0, 6))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd0;
         3: return 32'h7FFF_FFFF;
         4: begin v = int'($urandom_range(0, 40)) - 20; return 32'(v); end
         default: return $urandom();
      endcase
   endfunction

   // One operation; lit=1 adds literal result checks. Latency counts negedges
   // from the start drive to the rdy cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit lit,
                         input logic [31:0] lc, input logic lex, input logic [31:0] lr,
                         input int llat, input int inject_at);
      int n;
      bit got;
      logic [31:0] q, rm;
      logic e;
      bit spec;
      ref_div(a, b, q, rm, e, spec);
      @(negedge clock);
      start = 1'b1; ap = a; bp = b;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clock);
         n++;
         start = (n == inject_at);
         if (start) begin ap = 32'd1; bp = 32'd1; end
         else begin ap = $urandom(); bp = $urandom(); end
         if (rdy) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
         check("rdy_timeout", 32'd0, 32'd1);
      end else begin
         check("latency", 32'(n), spec ? 32'd2 : 32'd33);
         if (lit) begin
            check("lit_c", c, lc);
            check("lit_ex", {31'd0, ex}, {31'd0, lex});
            check("lit_lat", 32'(n), 32'(llat));
`ifdef DIV_REMAINDER_EN
            check("lit_r", r, lr);
`endif
         end
      end
   endtask

   initial begin
      int rdy_seen;
      reset_n = 1'b0; start = 1'b0; ap = '0; bp = '0;
      #23;
      check("rst_c", c, 32'd0);
      check("rst_ex", {31'd0, ex}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdy", {31'd0, rdy}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      run_op(32'd100,        32'd7,          1'b1, 32'd14,         1'b0, 32'd2,          33, -1);
      run_op(32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  1'b0, 32'hFFFF_FFFE,  33, -1);
      run_op(32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         1'b0, 32'hFFFF_FFFE,  33, -1);
      run_op(32'd5,          32'd0,          1'b1, 32'd0,          1'b1, 32'd5,          2,  -1);
      run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  1'b1, 32'd0,          2,  -1);
      run_op(32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  1'b0, 32'd0,          33, -1);
      run_op(32'd0,          32'hFFFF_FFFB,  1'b1, 32'd0,          1'b0, 32'd0,          33, -1);
      run_op(32'd100,        32'd7,          1'b1, 32'd14,         1'b0, 32'd2,          33, 10);

      // Abort by reset mid-run; c held 14 from the previous result.
      @(negedge clock);
      start = 1'b1; ap = 32'hFFFF_FF9C; bp = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (19) @(negedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_c", c, 32'd0);
      check("abort_rdy", {31'd0, rdy}, 32'd0);
      repeat (3) @(negedge clock);
      #3 reset_n = 1'b1;
      rdy_seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (rdy) rdy_seen++;
      end
      check("abort_no_rdy", 32'(rdy_seen), 32'd0);

      for (int i = 0; i < 40; i++)
         run_op(pick(), pick(), 1'b0, '0, 1'b0, '0, 0, (i % 4 == 0) ? int'($urandom_range(2, 30)) : -1);

      // Start held high with operands churning every cycle.
      repeat (150) begin
         @(negedge clock);
         start = 1'b1; ap = pick(); bp = pick();
      end
      @(negedge clock);
      start = 1'b0;
      repeat (40) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
